// File: rtl/imem_responder_if.sv
// Fetch read port and program-load stream of the instruction-memory responder.
// Load stream: a word transfers on a rising clk_i edge where ld_valid_i and
// ld_ready_o are both high; ld_data_i/ld_last_i are only meaningful with ld_valid_i.
interface imem_responder_if;
    logic [31:0] im_addr_i;
    logic [31:0] im_dout_o;
    logic        im_err_o;
    logic        loading_o;
    logic        ld_start_i;
    logic [31:0] ld_base_i;
    logic        ld_valid_i;
    logic [31:0] ld_data_i;
    logic        ld_last_i;
    logic        ld_ready_o;
    logic        ld_done_o;
    logic [15:0] ld_count_o;

    modport master (
        output im_addr_i, ld_start_i, ld_base_i, ld_valid_i, ld_data_i, ld_last_i,
        input  im_dout_o, im_err_o, loading_o, ld_ready_o, ld_done_o, ld_count_o
    );

    modport slave (
        input  im_addr_i, ld_start_i, ld_base_i, ld_valid_i, ld_data_i, ld_last_i,
        output im_dout_o, im_err_o, loading_o, ld_ready_o, ld_done_o, ld_count_o
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with a registered one-cycle read port and a streaming
// program-load FSM that stalls the core (loading_o) while words are written.
module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    imem_responder_if.slave   bus,
    output logic [1:0]        dbg_state_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   wptr;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [AW-1:0]   rd_idx;
    logic            aligned;
    logic            in_range;
    logic            we;
    logic            unused_base;

    assign rd_idx   = bus.im_addr_i[AW+1:2];
    assign aligned  = (bus.im_addr_i[1:0] == 2'b00);
    assign in_range = ((bus.im_addr_i >> (AW + 2)) == 32'd0);
    // Only the word-index bits of the load base matter.
    assign unused_base = ^{bus.ld_base_i[31:AW+2], bus.ld_base_i[1:0]};

    // Writes happen only in LOAD, so a read can never collide with a write.
    assign we = (state == LOAD) && bus.ld_valid_i && !rst_i;

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[wptr] <= bus.ld_data_i;
        end
    end

    assign dbg_state_o = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            wptr           <= '0;
            bus.im_dout_o  <= NOP_WORD;
            bus.im_err_o   <= 1'b0;
            bus.ld_ready_o <= 1'b0;
            bus.ld_done_o  <= 1'b0;
            bus.loading_o  <= 1'b0;
            bus.ld_count_o <= 16'd0;
        end else begin
            bus.ld_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (aligned && in_range) begin
                        bus.im_dout_o <= mem[rd_idx];
                        bus.im_err_o  <= 1'b0;
                    end else begin
                        bus.im_dout_o <= NOP_WORD;
                        bus.im_err_o  <= 1'b1;
                    end
                    if (bus.ld_start_i) begin
                        state          <= LOAD;
                        wptr           <= bus.ld_base_i[AW+1:2];
                        bus.ld_count_o <= 16'd0;
                        bus.ld_ready_o <= 1'b1;
                        bus.loading_o  <= 1'b1;
                    end
                end
                LOAD: begin
                    bus.im_dout_o <= NOP_WORD;
                    bus.im_err_o  <= 1'b0;
                    if (bus.ld_valid_i) begin
                        wptr <= wptr + 1'b1;
                        if (bus.ld_count_o != 16'hFFFF) begin
                            bus.ld_count_o <= bus.ld_count_o + 16'd1;
                        end
                        if (bus.ld_last_i) begin
                            state          <= DONE;
                            bus.ld_ready_o <= 1'b0;
                            bus.ld_done_o  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    bus.im_dout_o  <= NOP_WORD;
                    bus.im_err_o   <= 1'b0;
                    bus.ld_ready_o <= 1'b0;
                    bus.loading_o  <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    bus.im_dout_o  <= NOP_WORD;
                    bus.im_err_o   <= 1'b0;
                    bus.ld_ready_o <= 1'b0;
                    bus.loading_o  <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed load/read sequences, a
// vector table of reads, and a randomized run against a behavioural model.
module tb_imem_responder;
    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          M_IDLE = 0;
    localparam int          M_LOAD = 1;
    localparam int          M_DONE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    imem_responder_if bus();

    imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_phase = M_IDLE;
    int          m_wptr  = 0;
    int          m_count = 0;
    logic [33:0] exp_q [$];   // {known, err, dout} per read request

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply current inputs for one clock edge, advance the model, compare all outputs.
    task automatic tick();
        logic [33:0] e;
        int idx;
        if (rst) begin
            e = {1'b1, 1'b0, NOP};
        end else if (m_phase != M_IDLE) begin
            e = {1'b1, 1'b0, NOP};
        end else if (bus.im_addr_i[1:0] != 2'b00 || (bus.im_addr_i / 4) >= DEPTH) begin
            e = {1'b1, 1'b1, NOP};
        end else begin
            idx = int'(bus.im_addr_i / 4);
            e = {m_known[idx], 1'b0, m_mem[idx]};
        end
        exp_q.push_back(e);

        if (rst) begin
            m_phase = M_IDLE;
            m_count = 0;
        end else begin
            case (m_phase)
                M_IDLE: if (bus.ld_start_i) begin
                    m_phase = M_LOAD;
                    m_wptr  = int'((bus.ld_base_i / 4) % DEPTH);
                    m_count = 0;
                end
                M_LOAD: if (bus.ld_valid_i) begin
                    m_mem[m_wptr]   = bus.ld_data_i;
                    m_known[m_wptr] = 1'b1;
                    m_wptr  = (m_wptr + 1) % DEPTH;
                    m_count = (m_count < 65535) ? m_count + 1 : 65535;
                    if (bus.ld_last_i) m_phase = M_DONE;
                end
                default: m_phase = M_IDLE;
            endcase
        end

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e[33]) chk("im_dout", bus.im_dout_o, e[31:0]);
        chk("im_err", {31'd0, bus.im_err_o}, {31'd0, e[32]});
        chk("ld_ready", {31'd0, bus.ld_ready_o}, (m_phase == M_LOAD) ? 32'd1 : 32'd0);
        chk("ld_done", {31'd0, bus.ld_done_o}, (m_phase == M_DONE) ? 32'd1 : 32'd0);
        chk("loading", {31'd0, bus.loading_o}, (m_phase != M_IDLE) ? 32'd1 : 32'd0);
        chk("ld_count", {16'd0, bus.ld_count_o}, m_count);
    endtask

    task automatic quiet_inputs();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b0;
        bus.ld_last_i  = 1'b0;
        bus.ld_data_i  = 32'd0;
        bus.ld_base_i  = 32'd0;
    endtask

    task automatic do_load(input logic [31:0] base, input logic [31:0] d [4], input int n);
        bus.ld_start_i = 1'b1;
        bus.ld_base_i  = base;
        tick();
        bus.ld_start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.ld_valid_i = 1'b1;
            bus.ld_data_i  = d[i];
            bus.ld_last_i  = (i == n - 1);
            tick();
        end
        bus.ld_valid_i = 1'b0;
        bus.ld_last_i  = 1'b0;
        tick();  // DONE cycle
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.im_addr_i = addr;
        tick();
        chk(name, bus.im_dout_o, exp);
        chk({name, "_err"}, {31'd0, bus.im_err_o}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] dout;
        logic        err;
    } rd_vec_t;

    rd_vec_t     vecs [7];
    logic [31:0] wd   [4];

    initial begin
        vecs[0] = '{addr: 32'h10,             dout: 32'hA1, err: 1'b0};
        vecs[1] = '{addr: 32'h14,             dout: 32'hB2, err: 1'b0};
        vecs[2] = '{addr: 32'h18,             dout: 32'hC3, err: 1'b0};
        vecs[3] = '{addr: 32'h2,              dout: NOP,    err: 1'b1};
        vecs[4] = '{addr: 32'h14,             dout: 32'hB2, err: 1'b0};
        vecs[5] = '{addr: 32'(4 * DEPTH),     dout: NOP,    err: 1'b1};
        vecs[6] = '{addr: 32'h10,             dout: 32'hA1, err: 1'b0};

        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        quiet_inputs();
        bus.im_addr_i = 32'd0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_dout", bus.im_dout_o, NOP);
        chk("rst_err", {31'd0, bus.im_err_o}, 32'd0);
        chk("rst_loading", {31'd0, bus.loading_o}, 32'd0);
        chk("rst_ready", {31'd0, bus.ld_ready_o}, 32'd0);
        chk("rst_count", {16'd0, bus.ld_count_o}, 32'd0);
        rst = 1'b0;

        // Basic load of three words at 0x10
        wd = '{32'hA1, 32'hB2, 32'hC3, 32'h0};
        bus.ld_start_i = 1'b1;
        bus.ld_base_i  = 32'h10;
        tick();
        bus.ld_start_i = 1'b0;
        chk("load_ready", {31'd0, bus.ld_ready_o}, 32'd1);
        chk("load_stall", {31'd0, bus.loading_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid_i = 1'b1;
            bus.ld_data_i  = wd[i];
            bus.ld_last_i  = (i == 2);
            tick();
        end
        quiet_inputs();
        chk("done_pulse", {31'd0, bus.ld_done_o}, 32'd1);
        chk("done_count", {16'd0, bus.ld_count_o}, 32'd3);
        chk("done_ready", {31'd0, bus.ld_ready_o}, 32'd0);
        chk("done_stall", {31'd0, bus.loading_o}, 32'd1);
        tick();
        chk("done_fall", {31'd0, bus.ld_done_o}, 32'd0);
        chk("stall_fall", {31'd0, bus.loading_o}, 32'd0);

        // Read vector table
        foreach (vecs[i]) begin
            bus.im_addr_i = vecs[i].addr;
            tick();
            chk($sformatf("vec%0d_dout", i), bus.im_dout_o, vecs[i].dout);
            chk($sformatf("vec%0d_err", i), {31'd0, bus.im_err_o}, {31'd0, vecs[i].err});
        end

        // Valid gaps and ld_start_i raised mid-load; base low bits ignored
        bus.ld_start_i = 1'b1;
        bus.ld_base_i  = 32'h43;
        tick();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b1; bus.ld_data_i = 32'hE1; tick();
        bus.ld_valid_i = 1'b0; bus.ld_start_i = 1'b1; bus.ld_base_i = 32'h80; tick();
        bus.ld_valid_i = 1'b1; bus.ld_data_i = 32'hE2; tick();
        bus.ld_valid_i = 1'b0; bus.ld_start_i = 1'b0; tick();
        chk("gap_count", {16'd0, bus.ld_count_o}, 32'd2);
        bus.ld_valid_i = 1'b1; bus.ld_data_i = 32'hE3; bus.ld_last_i = 1'b1; tick();
        quiet_inputs();
        chk("gap_count_final", {16'd0, bus.ld_count_o}, 32'd3);
        tick();
        rd_chk("gap_w0", 32'h40, 32'hE1);
        rd_chk("gap_w1", 32'h44, 32'hE2);
        rd_chk("gap_w2", 32'h48, 32'hE3);
        rd_chk("gap_keep", 32'h10, 32'hA1);

        // Wrap past the top index
        wd = '{32'hD1, 32'hD2, 32'h0, 32'h0};
        do_load(32'(4 * (DEPTH - 1)), wd, 2);
        rd_chk("wrap_top", 32'(4 * (DEPTH - 1)), 32'hD1);
        rd_chk("wrap_bottom", 32'h0, 32'hD2);

        // Reset after one word of a load
        wd = '{32'h11, 32'h22, 32'h33, 32'h0};
        do_load(32'h60, wd, 3);
        bus.ld_start_i = 1'b1; bus.ld_base_i = 32'h60; tick();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b1; bus.ld_data_i = 32'h99; tick();
        bus.ld_valid_i = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("abort_stall", {31'd0, bus.loading_o}, 32'd0);
        chk("abort_count", {16'd0, bus.ld_count_o}, 32'd0);
        chk("abort_ready", {31'd0, bus.ld_ready_o}, 32'd0);
        rd_chk("abort_w0", 32'h60, 32'h99);
        rd_chk("abort_w1", 32'h64, 32'h22);
        rd_chk("abort_w2", 32'h68, 32'h33);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.ld_start_i = ($urandom_range(0, 9) == 0);
            bus.ld_base_i  = $urandom;
            bus.ld_valid_i = ($urandom_range(0, 2) != 0);
            bus.ld_data_i  = $urandom;
            bus.ld_last_i  = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0:       bus.im_addr_i = $urandom;
                1:       bus.im_addr_i = {22'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
                default: bus.im_addr_i = {22'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
            endcase
            tick();
        end
        rst = 1'b0;
        quiet_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
